booth_mult_seq: RTL



---
 rtl/booth_mult_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per clock, start/done handshake.
// Define BOOTH_UNSIGNED_EN to add the tc port (tc=1 signed, tc=0 unsigned operands).
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 tc,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_UNSIGNED_EN
    // One extra operand bit lets unsigned operands be treated as positive signed numbers.
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    localparam int AW = EW + 1;
    localparam int CW = $clog2(EW + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  a, m;
    logic [EW-1:0]  q;
    logic           q_m1;
    logic [CW-1:0]  cnt;

    logic [EW-1:0]  q_load;
    logic [AW-1:0]  m_load;
    logic [AW-1:0]  addend, sum, a_sh;
    logic [EW-1:0]  q_sh;
    logic           cin;
    logic           accept, last_step;

`ifdef BOOTH_UNSIGNED_EN
    logic ext_q, ext_m;
    assign ext_q  = tc & multiplier[WIDTH-1];
    assign ext_m  = tc & multiplicand[WIDTH-1];
    assign q_load = {ext_q, multiplier};
    assign m_load = {{2{ext_m}}, multiplicand};
`else
    assign q_load = multiplier;
    assign m_load = {multiplicand[WIDTH-1], multiplicand};
`endif

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (cnt == CW'(1));

    // Booth recode of {Q[0], q_m1}: subtract is A + ~M + 1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        addend = '0;
        cin    = 1'b0;
        case ({q[0], q_m1})
            2'b01:   addend = m;
            2'b10: begin
                addend = ~m;
                cin    = 1'b1;
            end
            default: ;
        endcase
        sum  = a + addend + {{(AW-1){1'b0}}, cin};
        a_sh = {sum[AW-1], sum[AW-1:1]};
        q_sh = {sum[0], q[EW-1:1]};
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            a    <= '0;
            q    <= q_load;
            q_m1 <= 1'b0;
            m    <= m_load;
            cnt  <= CW'(EW);
        end else if (state == RUN) begin
            a    <= a_sh;
            q    <= q_sh;
            q_m1 <= q[0];
            cnt  <= cnt - CW'(1);
            if (last_step) product <= {a_sh[2*WIDTH-EW-1:0], q_sh};
        end
    end

endmodule
